// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage: single-issue execute/memory stage with an APB master for
// loads/stores. Define EX_MEM_PSLVERR_EN to squash error completions. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_mem_stage #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 32,
  parameter int MADDR_W = 6,
  parameter int BOFF_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [2:0]         funct,
  input  logic [1:0]         shamt,
  input  logic [DATA_W-1:0]  reg1data,
  input  logic [DATA_W-1:0]  reg2data,
  input  logic [7:0]         idata,
  input  logic [7:0]         jtarget,
  input  logic [BOFF_W-1:0]  boffset,
  input  logic [MADDR_W-1:0] memaddr,
  input  logic [PC_W-1:0]    pc_in,
  output logic               wb_valid,
  output logic [DATA_W-1:0]  wb_data,
  output logic               wb_regwrite,
  output logic [PC_W-1:0]    pc_next,
  output logic               pc_redirect,
  output logic [MADDR_W-1:0] paddr,
  output logic               pwrite,
  output logic               psel,
  output logic               penable,
  output logic [DATA_W-1:0]  pwdata,
  input  logic [DATA_W-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_I   = 2'b01;
  localparam logic [1:0] OP_BNE = 2'b10;

  logic [1:0]         state_q, state_d;
  logic               wb_valid_q;
  logic [DATA_W-1:0]  wb_data_q;
  logic               wb_regwrite_q;
  logic [PC_W-1:0]    pc_next_q;
  logic               pc_redirect_q;
  logic [MADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic               store_q;

  logic               accept;
  logic               is_mem;
  logic               is_store;
  logic [DATA_W-1:0]  alu_d;
  logic               regwrite_d;
  logic [PC_W-1:0]    pc_next_d;
  logic               redirect_d;
  logic               xfer_err;
  logic               slt_bit;
  logic [PC_W-1:0]    boff_sext;

`ifdef EX_MEM_PSLVERR_EN
  assign xfer_err = pslverr;
`else
  assign xfer_err = 1'b0 & pslverr;
`endif

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign slt_bit   = $signed(reg1data) < $signed(reg2data);
  assign boff_sext = {{(PC_W-BOFF_W){boffset[BOFF_W-1]}}, boffset};

  always_comb begin
    alu_d      = '0;
    regwrite_d = 1'b0;
    is_mem     = 1'b0;
    is_store   = 1'b0;
    pc_next_d  = pc_in + PC_W'(1);
    redirect_d = 1'b0;
    case (op)
      OP_R: begin
        regwrite_d = 1'b1;
        case (funct)
          3'b000:  alu_d = reg1data + reg2data;
          3'b001:  alu_d = reg1data - reg2data;
          3'b010:  alu_d = reg1data & reg2data;
          3'b011:  alu_d = reg1data | reg2data;
          3'b100:  alu_d = reg1data ^ reg2data;
          3'b101:  alu_d = reg1data << shamt;
          3'b110:  alu_d = reg1data >> shamt;
          default: alu_d = {{(DATA_W-1){1'b0}}, slt_bit};
        endcase
      end
      OP_I: begin
        case (funct)
          3'b000: begin
            alu_d      = reg1data + DATA_W'(idata);
            regwrite_d = 1'b1;
          end
          3'b001: begin
            alu_d      = {idata, {(DATA_W-8){1'b0}}};
            regwrite_d = 1'b1;
          end
          3'b010:  is_mem = 1'b1;
          3'b011: begin
            is_mem   = 1'b1;
            is_store = 1'b1;
          end
          default: ;
        endcase
      end
      OP_BNE: begin
        if (reg1data != reg2data) begin
          pc_next_d  = pc_in + PC_W'(1) + boff_sext;
          redirect_d = 1'b1;
        end
      end
      default: begin
        // funct 001 jumps to the register value; every other encoding is PC-relative.
        redirect_d = 1'b1;
        pc_next_d  = (funct == 3'b001) ? PC_W'(reg1data) : pc_in + PC_W'(jtarget);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept && is_mem) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_regwrite_q <= 1'b0;
      pc_next_q     <= '0;
      pc_redirect_q <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      store_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      if (accept) begin
        pc_next_q     <= pc_next_d;
        pc_redirect_q <= redirect_d;
        if (is_mem) begin
          paddr_q  <= memaddr;
          pwdata_q <= reg2data;
          store_q  <= is_store;
        end else begin
          wb_valid_q    <= 1'b1;
          wb_data_q     <= alu_d;
          wb_regwrite_q <= regwrite_d;
        end
      end
      // Completion and acceptance never coincide: acceptance requires IDLE.
      if (state_q == S_ACCESS && pready) begin
        wb_valid_q    <= 1'b1;
        wb_regwrite_q <= !store_q && !xfer_err;
        wb_data_q     <= (store_q || xfer_err) ? '0 : prdata;
      end
    end
  end

  assign psel        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable     = (state_q == S_ACCESS);
  assign pwrite      = psel && store_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_regwrite = wb_regwrite_q;
  assign pc_next     = pc_next_q;
  assign pc_redirect = pc_redirect_q;

endmodule

`default_nettype wire

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16: operand, result and APB data width.
REQ-002 SHALL have parameter PC_W, default 32: program-counter width.
REQ-003 SHALL have parameter MADDR_W, default 6: data-memory address width.
REQ-004 SHALL have parameter BOFF_W, default 5: branch-offset width, two's complement.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction presented
- in_ready  out  1  stage can accept
- op  in  2  00 R-type, 01 I/mem, 10 bne, 11 jump
- funct  in  3  sub-operation
- shamt  in  2  shift amount
- reg1data, reg2data  in  DATA_W  operands
- idata  in  8  immediate
- jtarget  in  8  jump offset
- boffset  in  BOFF_W  branch offset
- memaddr  in  MADDR_W  data address
- pc_in  in  PC_W  instruction PC
- wb_valid  out  1  result strobe
- wb_data  out  DATA_W  result
- wb_regwrite  out  1  register write enable
- pc_next  out  PC_W  next PC
- pc_redirect  out  1  taken branch/jump
- paddr  out  MADDR_W, pwrite/psel/penable  out  1, pwdata  out  DATA_W  APB master
- prdata  in  DATA_W, pready/pslverr  in  1  APB completer

Function
REQ-007 SHALL accept an instruction when in_valid and in_ready are both 1; in_ready SHALL be 1 only in state IDLE and not in reset.
REQ-008 R-type funct SHALL give: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll by shamt, 110 srl by shamt, 111 slt (signed, result 1/0); arithmetic wraps modulo 2^DATA_W.
REQ-009 op=01 funct SHALL give: 000 addi (idata zero-extended), 001 lui (idata in the top 8 bits, rest 0), 010 load, 011 store, 1xx no-op.
REQ-010 wb_regwrite SHALL be 1 for op=00, op=01 with funct<=001, and completed loads; otherwise 0.
REQ-011 Non-memory ops SHALL produce wb_valid=1 for exactly one cycle, the cycle after acceptance, with wb_data, wb_regwrite, pc_next and pc_redirect registered.
REQ-012 pc_next SHALL be pc_in+1 by default.
REQ-013 For bne with reg1data!=reg2data, pc_next SHALL be pc_in+1+sign-extended boffset and pc_redirect SHALL be 1.
REQ-014 For a jump, pc_next SHALL be pc_in+zero-extended jtarget when funct=000, or zero-extended reg1data when funct=001; pc_redirect SHALL be 1.
REQ-015 Load/store SHALL use the FSM IDLE -> SETUP (psel=1, penable=0) -> ACCESS (psel=1, penable=1); the FSM SHALL remain in ACCESS while pready=0 and SHALL return to IDLE on pready=1.
REQ-016 paddr, pwrite and pwdata (=reg2data) SHALL be captured at acceptance and held stable through SETUP and ACCESS.
REQ-017 On pready=1 for a load, prdata SHALL be registered to wb_data with wb_valid=1 the next cycle; a store SHALL strobe wb_valid with wb_regwrite=0.
REQ-018 Outside SETUP and ACCESS, psel, penable and pwrite SHALL be 0.
REQ-019 Minimum load latency SHALL be 3 cycles from acceptance to wb_valid, plus one cycle per wait state.

Reset
REQ-020 rst SHALL force state IDLE and all outputs to 0, including pc_next, in_ready and the APB outputs, on the next clock edge.
REQ-021 rst asserted during SETUP or ACCESS SHALL abandon the transfer, deassert psel the next cycle, and produce no wb_valid.

Configuration
REQ-022 With EX_MEM_PSLVERR_EN defined, a completion with pslverr=1 SHALL force wb_regwrite=0 and wb_data=0 for that strobe.
REQ-023 Without EX_MEM_PSLVERR_EN, pslverr SHALL be ignored.

Verification
REQ-024 Accept add with reg1=0x7FFF and reg2=0x0001 -> next cycle: wb_valid=1, wb_data=0x8000, wb_regwrite=1.
REQ-025 Accept bne with reg1=3, reg2=4, boffset=5'h1E, pc_in=0x10 -> pc_next=0x0F, pc_redirect=1.
REQ-026 Accept load with memaddr=0x05, pready low for 2 ACCESS cycles, prdata=0xBEEF -> paddr=0x05 held, wb_valid at acceptance+5, wb_data=0xBEEF.
REQ-027 Accept store, then assert rst in ACCESS -> psel=0 next cycle, no wb_valid, in_ready=1 after rst releases.
REQ-028 With EX_MEM_PSLVERR_EN defined, a load completing with pslverr=1 -> wb_valid=1, wb_regwrite=0, wb_data=0.
REQ-029 Present in_valid during ACCESS -> in_ready=0, instruction not consumed until the FSM returns to IDLE.
